// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
//
// Writer side of the instruction memory. A framed binary image arrives as a
// byte stream (UART RX, JTAG shifter, ...) and is written word-by-word into
// the instruction RAM write port. The core is held stalled for the whole
// download, and the end of the frame is reported with a one-cycle done pulse
// together with a sticky checksum/length error flag.
//
// Frame: SyncByte, LEN_LO, LEN_HI (word count N, little-endian),
//        4*N data bytes (each word little-endian), CSUM (8-bit sum of data).
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active-high
//   in_valid  in   byte source has a byte
//   in_data   in   byte value
//   in_ready  out  loader accepts a byte this cycle (transfer = valid & ready)
//   wren      out  one-cycle write strobe to the instruction RAM
//   addr      out  word address of the write
//   wrdata    out  word to write
//   cpu_hold  out  stall/reset request to the core while a frame is loading
//   done      out  one-cycle pulse at the end of every frame (good or bad)
//   err       out  sticky error flag, cleared by the next accepted SyncByte
//
// All outputs are registered. They are derived from the next state so that
// each output is aligned with the state it belongs to (e.g. wren is high
// exactly while the FSM sits in WRITE).
// -----------------------------------------------------------------------------
module inst_loader #(
  parameter int unsigned AddrWidth = 10,
  parameter logic [7:0]  SyncByte  = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 wren,
  output logic [AddrWidth-1:0] addr,
  output logic [31:0]          wrdata,
  output logic                 cpu_hold,
  output logic                 done,
  output logic                 err
);

  // Largest legal word count: the whole RAM, never more.
  localparam logic [16:0] MaxWords = 17'(2 ** AddrWidth);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CSUM   = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t               state_q;
  logic                 in_ready_q;
  logic                 wren_q;
  logic [AddrWidth-1:0] addr_q;
  logic [31:0]          wrdata_q;
  logic                 cpu_hold_q;
  logic                 done_q;
  logic                 err_q;
  logic [7:0]           len_lo_q;
  logic [15:0]          words_q;   // words still to be written in this frame
  logic [1:0]           idx_q;     // byte lane inside the current word
  logic [7:0]           csum_q;    // running 8-bit sum of data bytes

  // ---------------------------------------------------------------------------
  // Next-state / helper signals
  // ---------------------------------------------------------------------------
  state_t      state_d;
  logic        xfer_d;
  logic        sync_hit_d;
  logic [15:0] len_d;
  logic        len_over_d;
  logic [7:0]  csum_d;
  logic [15:0] words_d;
  logic [31:0] wrdata_d;
  logic        in_ready_d;
  logic        cpu_hold_d;
  logic        done_d;

  // A byte moves only when the source offers it and we advertised ready.
  assign xfer_d     = in_valid & in_ready_q;
  assign sync_hit_d = xfer_d & (state_q == S_IDLE) & (in_data == SyncByte);
  assign len_d      = {in_data, len_lo_q};
  assign len_over_d = ({1'b0, len_d} > MaxWords);
  assign csum_d     = csum_q + in_data;
  assign words_d    = words_q - 16'd1;

  // Merge the incoming byte into its lane of the word being assembled.
  always_comb begin
    wrdata_d = wrdata_q;
    case (idx_q)
      2'd0:    wrdata_d[7:0]   = in_data;
      2'd1:    wrdata_d[15:8]  = in_data;
      2'd2:    wrdata_d[23:16] = in_data;
      2'd3:    wrdata_d[31:24] = in_data;
      default: wrdata_d        = wrdata_q;
    endcase
  end

  // Frame sequencing: state transitions only.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        // Anything other than the sync marker is dropped while hunting.
        if (sync_hit_d) begin
          state_d = S_LEN_LO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LEN_LO: begin
        if (xfer_d) begin
          state_d = S_LEN_HI;
        end else begin
          state_d = S_LEN_LO;
        end
      end
      S_LEN_HI: begin
        if (!xfer_d) begin
          state_d = S_LEN_HI;
        end else if (len_over_d) begin
          state_d = S_ERR;
        end else if (len_d == 16'd0) begin
          state_d = S_CSUM;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer_d && (idx_q == 2'd3)) begin
          state_d = S_WRITE;
        end else begin
          state_d = S_DATA;
        end
      end
      S_WRITE: begin
        if (words_q == 16'd1) begin
          state_d = S_CSUM;
        end else begin
          state_d = S_DATA;
        end
      end
      S_CSUM: begin
        if (!xfer_d) begin
          state_d = S_CSUM;
        end else if (in_data == csum_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values belonging to the state about to be entered.
  // WRITE, DONE and ERR take no byte: those are the single-cycle bubbles.
  always_comb begin
    in_ready_d = 1'b0;
    cpu_hold_d = 1'b0;
    done_d     = 1'b0;
    case (state_d)
      S_IDLE: begin
        in_ready_d = 1'b1;
      end
      S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM: begin
        in_ready_d = 1'b1;
        cpu_hold_d = 1'b1;
      end
      S_WRITE: begin
        cpu_hold_d = 1'b1;
      end
      S_DONE, S_ERR: begin
        done_d = 1'b1;
      end
      default: begin
        in_ready_d = 1'b0;
        cpu_hold_d = 1'b0;
        done_d     = 1'b0;
      end
    endcase
  end

  // State register, registered outputs and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      wrdata_q   <= 32'h0000_0000;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      len_lo_q   <= 8'h00;
      words_q    <= 16'h0000;
      idx_q      <= 2'd0;
      csum_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      wren_q     <= (state_d == S_WRITE);
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;

      // err is sticky across frames until a new frame actually starts.
      if (state_d == S_ERR) begin
        err_q <= 1'b1;
      end else if (sync_hit_d) begin
        err_q <= 1'b0;
      end else begin
        err_q <= err_q;
      end

      case (state_q)
        S_IDLE: begin
          if (sync_hit_d) begin
            csum_q <= 8'h00;
          end
        end
        S_LEN_LO: begin
          if (xfer_d) begin
            len_lo_q <= in_data;
          end
        end
        S_LEN_HI: begin
          // Address/lane only restart when data will really follow.
          if (xfer_d && !len_over_d && (len_d != 16'd0)) begin
            words_q <= len_d;
            addr_q  <= '0;
            idx_q   <= 2'd0;
          end
        end
        S_DATA: begin
          if (xfer_d) begin
            wrdata_q <= wrdata_d;
            csum_q   <= csum_d;
            idx_q    <= idx_q + 2'd1;  // wraps to 0 after lane 3
          end
        end
        S_WRITE: begin
          addr_q  <= addr_q + AddrWidth'(1);
          words_q <= words_d;
        end
        default: begin
          words_q <= words_q;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign wren     = wren_q;
  assign addr     = addr_q;
  assign wrdata   = wrdata_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// -----------------------------------------------------------------------------
// Bench for inst_loader. A byte-level frame model (position inside the frame,
// word count, running sum) predicts every output for every cycle; a single
// compare process checks the DUT against it on the falling edge. Directed
// frames additionally check the observed write/done logs against literals.
// -----------------------------------------------------------------------------
module tb_inst_loader;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          wren;
  logic [AW-1:0] addr;
  logic [31:0]   wrdata;
  logic          cpu_hold;
  logic          done;
  logic          err;

  int errors = 0;
  int checks = 0;

  inst_loader #(.AddrWidth(AW), .SyncByte(8'hA5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wren(wren), .addr(addr), .wrdata(wrdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Model expectations for the current cycle.
  logic          e_ready = 1'b0, e_wren = 1'b0, e_hold = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [31:0]   e_data = 32'h0;
  // Frame model state.
  bit            in_frame = 1'b0;
  int            pos = 0;
  int            nwords = 0;
  logic [7:0]    m_csum = 8'h00;
  logic [7:0]    m_lenlo = 8'h00;
  logic [31:0]   m_word = 32'h0;
  // Observed DUT events.
  logic [AW-1:0] wlog_addr[$];
  logic [31:0]   wlog_data[$];
  logic          dlog_err[$];
  // Stimulus.
  logic [7:0]    txq[$];
  bit            gaps = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare DUT with the model, then advance the model by one cycle.
  initial begin
    forever begin
      bit xfer;
      int idx;
      int n;
      @(negedge clk);
      chk("in_ready", 32'(in_ready), 32'(e_ready));
      chk("wren", 32'(wren), 32'(e_wren));
      chk("cpu_hold", 32'(cpu_hold), 32'(e_hold));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(e_err));
      if (e_wren) begin
        chk("addr", 32'(addr), 32'(e_addr));
        chk("wrdata", wrdata, e_data);
      end
      if (wren === 1'b1) begin
        wlog_addr.push_back(addr);
        wlog_data.push_back(wrdata);
      end
      if (done === 1'b1) dlog_err.push_back(err);

      xfer = e_ready && (in_valid === 1'b1);
      e_wren = 1'b0;
      e_done = 1'b0;
      if (rst) begin
        in_frame = 1'b0;
        e_err = 1'b0;
        e_hold = 1'b0;
        e_ready = 1'b0;
      end else begin
        if (xfer) begin
          if (!in_frame) begin
            if (in_data == 8'hA5) begin
              in_frame = 1'b1; pos = 1; m_csum = 8'h00; e_err = 1'b0;
            end
          end else if (pos == 1) begin
            m_lenlo = in_data; pos = 2;
          end else if (pos == 2) begin
            n = int'({in_data, m_lenlo});
            if (n > (1 << AW)) begin
              e_done = 1'b1; e_err = 1'b1; in_frame = 1'b0;
            end else begin
              nwords = n; pos = 3;
            end
          end else if (pos < 3 + 4 * nwords) begin
            idx = (pos - 3) % 4;
            m_word[8*idx +: 8] = in_data;
            m_csum = m_csum + in_data;
            if (idx == 3) begin
              e_wren = 1'b1;
              e_addr = AW'((pos - 3) / 4);
              e_data = m_word;
            end
            pos++;
          end else begin
            e_done = 1'b1;
            e_err = (in_data != m_csum);
            in_frame = 1'b0;
          end
        end
        e_hold = in_frame;
        e_ready = !(e_wren || e_done);
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    int waited;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0; in_data = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1; in_data = b;
    ok = 1'b0; waited = 0;
    while (!ok && waited <= 20) begin
      @(negedge clk);
      ok = (in_ready === 1'b1);
      @(posedge clk); #1;
      waited++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: byte %h not accepted after %0d cycles", b, waited);
    end
    in_valid = 1'b0; in_data = 8'($urandom);
  endtask

  task automatic send_all();
    while (txq.size() > 0) send_byte(txq.pop_front());
  endtask

  task automatic clear_logs();
    wlog_addr.delete(); wlog_data.delete(); dlog_err.delete();
  endtask

  task automatic push_bytes(input logic [31:0] w);
    txq.push_back(w[7:0]); txq.push_back(w[15:8]);
    txq.push_back(w[23:16]); txq.push_back(w[31:24]);
  endtask

  // Random frame with n words; bad corrupts the checksum byte.
  task automatic build_frame(input int n, input bit bad);
    logic [7:0] s;
    logic [7:0] b;
    s = 8'h00;
    txq.push_back(8'hA5);
    txq.push_back(8'(n)); txq.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      s = s + b;
      txq.push_back(b);
    end
    txq.push_back(bad ? s + 8'd1 : s);
  endtask

  task automatic frame2(input logic [7:0] cs);
    txq.push_back(8'hA5); txq.push_back(8'h02); txq.push_back(8'h00);
    push_bytes(32'h44332211); push_bytes(32'h88776655);
    txq.push_back(cs);
  endtask

  initial begin
    // Reset and idle.
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    chk("ready_after_rst_low", 32'(in_ready), 32'd0);
    idle(1);
    chk("ready_first_cycle", 32'(in_ready), 32'd1);
    chk("idle_hold", 32'(cpu_hold), 32'd0);
    idle(3);

    // Normal 2-word frame.
    clear_logs(); gaps = 1'b0;
    frame2(8'h64); send_all(); idle(3);
    chk("f1_nwr", 32'(wlog_addr.size()), 32'd2);
    chk("f1_a0", 32'(wlog_addr[0]), 32'd0);
    chk("f1_d0", wlog_data[0], 32'h44332211);
    chk("f1_a1", 32'(wlog_addr[1]), 32'd1);
    chk("f1_d1", wlog_data[1], 32'h88776655);
    chk("f1_ndone", 32'(dlog_err.size()), 32'd1);
    chk("f1_err", 32'(dlog_err[0]), 32'd0);

    // Bad checksum, sticky err survives idle and junk bytes.
    clear_logs();
    frame2(8'h65); send_all(); idle(5);
    chk("bad_nwr", 32'(wlog_addr.size()), 32'd2);
    chk("bad_err_at_done", 32'(dlog_err[0]), 32'd1);
    txq.push_back(8'h12); txq.push_back(8'h34); send_all(); idle(2);
    chk("bad_err_sticky", 32'(err), 32'd1);

    // Zero length clears err.
    clear_logs();
    txq.push_back(8'hA5); txq.push_back(8'h00); txq.push_back(8'h00); txq.push_back(8'h00);
    send_all(); idle(3);
    chk("zero_nwr", 32'(wlog_addr.size()), 32'd0);
    chk("zero_ndone", 32'(dlog_err.size()), 32'd1);
    chk("zero_err", 32'(dlog_err[0]), 32'd0);

    // Oversize: N = 1025.
    clear_logs();
    txq.push_back(8'hA5); txq.push_back(8'h01); txq.push_back(8'h04);
    txq.push_back(8'h11); txq.push_back(8'h22); txq.push_back(8'h33);
    send_all(); idle(3);
    chk("over_nwr", 32'(wlog_addr.size()), 32'd0);
    chk("over_err", 32'(dlog_err[0]), 32'd1);
    chk("over_ndone", 32'(dlog_err.size()), 32'd1);

    // Backpressure / gaps on the 2-word frame.
    clear_logs(); gaps = 1'b1;
    frame2(8'h64); send_all(); idle(3);
    chk("gap_nwr", 32'(wlog_addr.size()), 32'd2);
    chk("gap_d0", wlog_data[0], 32'h44332211);
    chk("gap_d1", wlog_data[1], 32'h88776655);
    chk("gap_err", 32'(dlog_err[0]), 32'd0);

    // Reset mid-frame, then a 1-word frame.
    clear_logs(); gaps = 1'b0;
    txq.push_back(8'hA5); txq.push_back(8'h02); txq.push_back(8'h00);
    txq.push_back(8'h11); txq.push_back(8'h22);
    send_all();
    rst = 1'b1; idle(3); rst = 1'b0; idle(2);
    txq.push_back(8'hA5); txq.push_back(8'h01); txq.push_back(8'h00);
    push_bytes(32'hDDCCBBAA); txq.push_back(8'h0E);
    send_all(); idle(3);
    chk("rst_nwr", 32'(wlog_addr.size()), 32'd1);
    chk("rst_a0", 32'(wlog_addr[0]), 32'd0);
    chk("rst_d0", wlog_data[0], 32'hDDCCBBAA);
    chk("rst_err", 32'(dlog_err[0]), 32'd0);

    // Largest legal frame fills the whole RAM.
    clear_logs();
    build_frame(1 << AW, 1'b0); send_all(); idle(3);
    chk("max_nwr", 32'(wlog_addr.size()), 32'(1 << AW));
    chk("max_last_addr", 32'(wlog_addr[(1 << AW) - 1]), 32'((1 << AW) - 1));
    chk("max_err", 32'(dlog_err[0]), 32'd0);

    // Randomized frames, junk, gaps and bad checksums.
    for (int f = 0; f < 30; f++) begin
      logic [7:0] j;
      gaps = bit'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) begin
        j = 8'($urandom);
        if (j == 8'hA5) j = 8'h5A;
        txq.push_back(j);
      end
      build_frame($urandom_range(0, 5), ($urandom_range(0, 3) == 0));
      send_all();
      idle($urandom_range(0, 3));
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
